// File: rtl/selector_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// selector_mode_ctrl_if
// Signal bundle between the configuration/scan registers (master side) and the
// selector sequencer (slave side). All signals are in the system-clock domain
// except TEG_STROBE, which is a raw tap of the ADC-TEG output clock.
//
// Signals:
//   MODE_REQ        [1:0]   steady mode request: 00 off, 01 DFE, 10 TEG, 11 off
//   TEG_BURST_START         single-cycle burst start pulse
//   BURST_LEN       [CW-1:0] TEG strobes per burst, sampled with the start pulse
//   TEG_STROBE              asynchronous ADC-TEG output clock tap
//   ENABLE_DFE              registered enable to the selector, DFE source
//   ENABLE_ADC_TEG          registered enable to the selector, ADC-TEG source
//   CUR_SEL         [1:0]   enabled source: 00 none, 01 DFE, 10 TEG
//   BUSY                    guard gap in progress or burst active
//   BURST_DONE              one-cycle pulse on burst completion
//   DBG_STATE       [1:0]   sequencer state: 0 IDLE, 1 DFE, 2 TEG, 3 GUARD
//
// Handshake: there is no valid/ready pair. TEG_BURST_START is a one-cycle
// request that is either accepted on the edge it is sampled (no burst active,
// BURST_LEN non-zero) or silently dropped; BUSY tells the master whether a
// request would currently be dropped. BURST_DONE is a one-cycle
// completion pulse with no back-pressure.
// -----------------------------------------------------------------------------
interface selector_mode_ctrl_if #(
    parameter int CW = 12
);
    logic [1:0]    MODE_REQ;
    logic          TEG_BURST_START;
    logic [CW-1:0] BURST_LEN;
    logic          TEG_STROBE;
    logic          ENABLE_DFE;
    logic          ENABLE_ADC_TEG;
    logic [1:0]    CUR_SEL;
    logic          BUSY;
    logic          BURST_DONE;
    logic [1:0]    DBG_STATE;

    modport master (
        output MODE_REQ, TEG_BURST_START, BURST_LEN, TEG_STROBE,
        input  ENABLE_DFE, ENABLE_ADC_TEG, CUR_SEL, BUSY, BURST_DONE, DBG_STATE
    );

    modport slave (
        input  MODE_REQ, TEG_BURST_START, BURST_LEN, TEG_STROBE,
        output ENABLE_DFE, ENABLE_ADC_TEG, CUR_SEL, BUSY, BURST_DONE, DBG_STATE
    );
endinterface

// File: rtl/selector_mode_ctrl.sv
// -----------------------------------------------------------------------------
// selector_mode_ctrl
// Sequences the digital output selector so that ENABLE_DFE and ENABLE_ADC_TEG
// are never high together. Every DFE<->TEG switch passes through a GUARD gap of
// GUARD_CYC cycles with both enables low; switching to or from "off" is
// immediate. Finite ADC-TEG capture bursts override the steady mode request
// and hand back to it automatically when the strobe count completes.
//
// Ports:
//   CLK     system clock, rising edge
//   RST_N   asynchronous active-low reset, synchronous release
//   sel_if  selector_mode_ctrl_if.slave bundle (mode request, burst control,
//           TEG strobe tap, enables, status)
// -----------------------------------------------------------------------------
module selector_mode_ctrl #(
    parameter int GUARD_CYC = 4,
    parameter int CW        = 12
) (
    input  logic                CLK,
    input  logic                RST_N,
    selector_mode_ctrl_if.slave sel_if
);
    // GUARD_CYC-1 is the largest value the guard counter ever holds.
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DFE   = 2'd1,
        S_TEG   = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_target;
    logic [GW-1:0] r_guard_cnt;
    logic [GW-1:0] w_guard_cnt_nxt;

    logic [CW-1:0] r_burst_len;
    logic [CW-1:0] r_burst_cnt;
    logic          r_burst_active;
    logic          r_burst_done;

    logic          r_en_dfe;
    logic          r_en_teg;

    logic          r_stb_s1;
    logic          r_stb_s2;
    logic          r_stb_s3;

    logic          w_tick;
    logic          w_burst_go;
    logic          w_count;
    logic          w_last;

    // -------------------------------------------------------------------------
    // Strobe path: two-flop synchroniser, third flop for rising-edge detect.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stb_s1 <= 1'b0;
            r_stb_s2 <= 1'b0;
            r_stb_s3 <= 1'b0;
        end else begin
            r_stb_s1 <= sel_if.TEG_STROBE;
            r_stb_s2 <= r_stb_s1;
            r_stb_s3 <= r_stb_s2;
        end
    end

    assign w_tick = r_stb_s2 & ~r_stb_s3;

    // -------------------------------------------------------------------------
    // Burst control
    // -------------------------------------------------------------------------
    assign w_burst_go = sel_if.TEG_BURST_START & ~r_burst_active &
                        (sel_if.BURST_LEN != '0);
    // Strobes only count once the TEG source is actually driving the selector.
    assign w_count    = w_tick & r_burst_active & (r_state == S_TEG);
    assign w_last     = w_count & ((r_burst_cnt + CW'(1)) == r_burst_len);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_burst_active <= 1'b0;
            r_burst_len    <= '0;
            r_burst_cnt    <= '0;
            r_burst_done   <= 1'b0;
        end else begin
            r_burst_done <= w_last;
            if (w_burst_go) begin
                r_burst_active <= 1'b1;
                r_burst_len    <= sel_if.BURST_LEN;
                r_burst_cnt    <= '0;
            end else if (w_last) begin
                r_burst_active <= 1'b0;
                r_burst_cnt    <= '0;
            end else if (w_count) begin
                r_burst_cnt <= r_burst_cnt + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Target source. The start pulse is folded in so a burst beats a mode
    // change arriving in the same cycle and no transient DFE target appears.
    // -------------------------------------------------------------------------
    always_comb begin
        w_target = S_IDLE;
        if (r_burst_active || w_burst_go) begin
            w_target = S_TEG;
        end else begin
            case (sel_if.MODE_REQ)
                2'b01:   w_target = S_DFE;
                2'b10:   w_target = S_TEG;
                default: w_target = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_guard_cnt_nxt = r_guard_cnt;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_target;
            end
            S_DFE: begin
                if (w_target == S_IDLE) begin
                    w_state_nxt = S_IDLE;
                end else if (w_target == S_TEG) begin
                    w_state_nxt     = S_GUARD;
                    w_guard_cnt_nxt = GW'(GUARD_CYC - 1);
                end
            end
            S_TEG: begin
                if (w_target == S_IDLE) begin
                    w_state_nxt = S_IDLE;
                end else if (w_target == S_DFE) begin
                    w_state_nxt     = S_GUARD;
                    w_guard_cnt_nxt = GW'(GUARD_CYC - 1);
                end
            end
            S_GUARD: begin
                // Destination is resolved only at expiry; the gap never restarts.
                if (r_guard_cnt == '0) begin
                    w_state_nxt = w_target;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt - GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Enables are decoded from the next state so they flip on the same edge
    // as the state register and stay glitch-free flop outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_guard_cnt <= '0;
            r_en_dfe    <= 1'b0;
            r_en_teg    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= w_guard_cnt_nxt;
            r_en_dfe    <= (w_state_nxt == S_DFE);
            r_en_teg    <= (w_state_nxt == S_TEG);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sel_if.ENABLE_DFE     = r_en_dfe;
    assign sel_if.ENABLE_ADC_TEG = r_en_teg;
    assign sel_if.CUR_SEL        = {r_en_teg, r_en_dfe};
    assign sel_if.BUSY           = (r_state == S_GUARD) | r_burst_active;
    assign sel_if.BURST_DONE     = r_burst_done;
    assign sel_if.DBG_STATE      = r_state;

endmodule

// File: tb/tb_selector_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_selector_mode_ctrl
// Self-checking bench for selector_mode_ctrl (GUARD_CYC=4, CW=12).
// Observed output word: {ENABLE_DFE, ENABLE_ADC_TEG, CUR_SEL[1:0], BUSY,
// BURST_DONE}. Inputs change on the falling edge; outputs are sampled on the
// next falling edge, one rising edge later.
// -----------------------------------------------------------------------------
module tb_selector_mode_ctrl;
    localparam int CW = 12;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_DFE   = 6'b100100;
    localparam logic [5:0] O_TEG   = 6'b011000;
    localparam logic [5:0] O_TEG_B = 6'b011010;
    localparam logic [5:0] O_DONE  = 6'b011001;
    localparam logic [5:0] O_GUARD = 6'b000010;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    selector_mode_ctrl_if #(.CW(CW)) bus ();

    selector_mode_ctrl #(
        .GUARD_CYC (4),
        .CW        (CW)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .sel_if (bus)
    );

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [1:0]    mode;
        logic          start;
        logic [CW-1:0] len;
        logic [5:0]    exp;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [5:0] outs();
        return {bus.ENABLE_DFE, bus.ENABLE_ADC_TEG, bus.CUR_SEL, bus.BUSY, bus.BURST_DONE};
    endfunction

    // Strobe train: n pulses, 3 cycles high every 7 cycles, first rising in cycle 'first'.
    function automatic logic stb(int j, int first, int n);
        return (j >= first) && ((j - first) < 7 * n) && (((j - first) % 7) < 3);
    endfunction

    task automatic check(input string name);
        logic [5:0] a;
        logic [5:0] e;
        a = outs();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: got %b but no expectation queued", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_miss++;
                $display("FAIL %s: got %b expected %b", name, a, e);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [1:0] mode, input logic start,
                         input logic [CW-1:0] len, input logic stb_v,
                         input logic [5:0] e, input string name);
        bus.MODE_REQ        = mode;
        bus.TEG_BURST_START = start;
        bus.BURST_LEN       = len;
        bus.TEG_STROBE      = stb_v;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        check(name);
    endtask

    // ---------------- mutual-exclusion monitor ----------------
    always @(negedge CLK) begin
        assert (!(bus.ENABLE_DFE && bus.ENABLE_ADC_TEG)) else begin
            n_miss++;
            $display("FAIL enable_mutex: got DFE=%b TEG=%b expected not both 1",
                     bus.ENABLE_DFE, bus.ENABLE_ADC_TEG);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] e;

        vecs[0]  = '{2'b00, 1'b0, 12'd0, O_IDLE};
        vecs[1]  = '{2'b01, 1'b0, 12'd0, O_DFE};
        vecs[2]  = '{2'b01, 1'b0, 12'd0, O_DFE};
        vecs[3]  = '{2'b10, 1'b0, 12'd0, O_GUARD};
        vecs[4]  = '{2'b10, 1'b0, 12'd0, O_GUARD};
        vecs[5]  = '{2'b10, 1'b0, 12'd0, O_GUARD};
        vecs[6]  = '{2'b10, 1'b0, 12'd0, O_GUARD};
        vecs[7]  = '{2'b10, 1'b0, 12'd0, O_TEG};
        vecs[8]  = '{2'b00, 1'b0, 12'd0, O_IDLE};
        vecs[9]  = '{2'b11, 1'b0, 12'd0, O_IDLE};
        vecs[10] = '{2'b10, 1'b0, 12'd0, O_TEG};
        vecs[11] = '{2'b11, 1'b0, 12'd0, O_IDLE};
        vecs[12] = '{2'b00, 1'b1, 12'd0, O_IDLE};
        vecs[13] = '{2'b01, 1'b0, 12'd0, O_DFE};
        vecs[14] = '{2'b10, 1'b0, 12'd0, O_GUARD};
        vecs[15] = '{2'b01, 1'b0, 12'd0, O_GUARD};
        vecs[16] = '{2'b01, 1'b0, 12'd0, O_GUARD};
        vecs[17] = '{2'b01, 1'b0, 12'd0, O_GUARD};
        vecs[18] = '{2'b01, 1'b0, 12'd0, O_DFE};
        vecs[19] = '{2'b00, 1'b0, 12'd0, O_IDLE};
        vecs[20] = '{2'b01, 1'b0, 12'd0, O_DFE};

        bus.MODE_REQ        = 2'b00;
        bus.TEG_BURST_START = 1'b0;
        bus.BURST_LEN       = '0;
        bus.TEG_STROBE      = 1'b0;
        RST_N               = 1'b1;
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        exp_q.push_back(O_IDLE);
        check("reset_state");
        RST_N = 1'b1;

        // Steady-mode table: enable latency, guard gap, 11 as off, zero-length start.
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].mode, vecs[i].start, vecs[i].len, 1'b0, vecs[i].exp,
                  $sformatf("table[%0d]", i));
        end

        // Burst from DFE: guard in, 3 counted strobes, guard out, strobes 4-5 ignored.
        for (int j = 0; j <= 40; j++) begin
            e = (j <= 3)  ? O_GUARD :
                (j <= 19) ? O_TEG_B :
                (j == 20) ? O_DONE  :
                (j <= 24) ? O_GUARD : O_DFE;
            cycle(2'b01, (j == 0), 12'd3, stb(j, 4, 5), e, $sformatf("burst_dfe[%0d]", j));
        end

        // Move to steady TEG.
        for (int j = 0; j <= 5; j++) begin
            e = (j <= 3) ? O_GUARD : O_TEG;
            cycle(2'b10, 1'b0, 12'd0, 1'b0, e, $sformatf("to_teg[%0d]", j));
        end

        // Burst started in steady TEG; mode drops to off, second start ignored.
        for (int j = 0; j <= 16; j++) begin
            e = (j <= 10) ? O_TEG_B : (j == 11) ? O_DONE : O_IDLE;
            cycle((j == 0) ? 2'b10 : 2'b00, (j == 0 || j == 3),
                  (j == 0) ? 12'd2 : CW'($urandom_range(1, 4095)),
                  stb(j, 2, 2), e, $sformatf("burst_teg[%0d]", j));
        end

        // Mode change and burst start together, then reset at count 1 of 3.
        for (int j = 0; j <= 5; j++) begin
            cycle(2'b01, (j == 0), 12'd3, stb(j, 2, 1), O_TEG_B, $sformatf("burst_rst[%0d]", j));
        end
        RST_N = 1'b0;
        #1;
        exp_q.push_back(O_IDLE);
        check("reset_async");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        exp_q.push_back(O_IDLE);
        check("reset_hold");
        bus.MODE_REQ        = 2'b00;
        bus.TEG_BURST_START = 1'b0;
        RST_N               = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cycle(2'b00, 1'b0, 12'd3, 1'($urandom_range(0, 1)), O_IDLE,
                  $sformatf("post_reset[%0d]", j));
        end

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/selector_mode_ctrl.md
Name: selector_mode_ctrl

Overview:
- Sequences the digital output selector: generates ENABLE_DFE / ENABLE_ADC_TEG so the two are never high together.
- Inserts a programmable guard gap on every source switch so OUT / OUT_CLK never carry a runt clock or a mixed word.
- Runs finite ADC-TEG capture bursts that return automatically to the requested steady mode.
- Sits between the configuration/scan registers and the selector, in the chip's system-clock domain.

Parameters:
GUARD_CYC, 4, number of CLK cycles both enables are held low between sources (must be ≥1)
CW, 12, width of burst length and burst counter

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
MODE_REQ  input  2  steady mode request, synchronous to CLK: 00 off, 01 DFE, 10 ADC_TEG, 11 treated as off
TEG_BURST_START  input  1  single-cycle pulse, starts an ADC_TEG burst
BURST_LEN  input  CW  number of TEG strobes per burst; sampled on the start pulse
TEG_STROBE  input  1  OUT_CLK_ADC_TEG tap, asynchronous to CLK
ENABLE_DFE  output  1  to selector, registered
ENABLE_ADC_TEG  output  1  to selector, registered
CUR_SEL  output  2  currently enabled source: 00 none, 01 DFE, 10 TEG
BUSY  output  1  high in GUARD state or while a burst is active
BURST_DONE  output  1  one-cycle pulse when the burst count completes

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, counters 0, strobe synchroniser cleared.
- States: IDLE, DFE, TEG, GUARD. Enables are decoded registered from state: DFE→ENABLE_DFE=1, TEG→ENABLE_ADC_TEG=1, IDLE/GUARD→both 0. CUR_SEL follows the enables.
- Target source: during a burst the target is TEG. Otherwise the target is MODE_REQ, with 11 mapped to off.
- IDLE with target DFE/TEG detected before edge k: the enable is high after edge k. No guard is applied when leaving IDLE.
- DFE/TEG with target off: the enable drops at edge k and the state goes to IDLE. No guard.
- DFE↔TEG switch detected before edge k: both enables drop at edge k and the state goes to GUARD with guard counter = GUARD_CYC−1.
  - The guard counter decrements each cycle.
  - In the cycle it reads 0, the next state is the target at that moment (DFE, TEG or IDLE).
  - Result: both enables are low for exactly GUARD_CYC cycles, and the new enable is high after edge k+GUARD_CYC.
- Target changes during GUARD: the guard does not restart. The destination is resolved at guard expiry. If the target equals the pre-guard source, the guard still runs to completion.
- Strobe path: TEG_STROBE passes through a 2-FF synchroniser, then a rising-edge detector, giving a one-cycle tick 2–3 CLK after the async edge.
- Burst start: TEG_BURST_START=1 with no burst active and BURST_LEN≠0 latches the length and sets burst_active.
  - BURST_LEN=0: the pulse is ignored.
  - A pulse while a burst is active is ignored.
- Burst counting: ticks count only while state=TEG and burst_active; ticks during GUARD are discarded.
  - When the count reaches the latched length, BURST_DONE pulses for 1 cycle (same edge as the final count), burst_active clears and the counter clears.
  - The target reverts to MODE_REQ and the switch rules above apply. Example: return to DFE goes through GUARD; return to off drops immediately.
- Burst start while already in steady TEG: no switch; counting begins on the next tick.
- BUSY = (state==GUARD) | burst_active.
- Simultaneous MODE_REQ change and burst start in the same cycle: the burst wins and MODE_REQ is honoured after the burst.
- Reset mid-burst or mid-guard: everything returns to IDLE asynchronously. No BURST_DONE is emitted.
- Invariant: ENABLE_DFE & ENABLE_ADC_TEG is never 1, in any cycle.

Test Plan:
- Reset, MODE_REQ=01 → ENABLE_DFE=1 one edge after the request; CUR_SEL=01; BUSY=0.
- DFE steady, MODE_REQ→10 at edge k → both enables 0 for cycles k..k+3; ENABLE_ADC_TEG=1 after edge k+4; BUSY=1 during the gap.
- MODE_REQ=01, BURST_LEN=3, start pulse, 5 async TEG_STROBE edges at 7-CLK spacing → guard 4 cycles, TEG on, BURST_DONE one cycle after the 3rd synced tick, 4-cycle guard, ENABLE_DFE=1; strobes 4–5 not counted.
- During a burst: MODE_REQ→00 and a second start pulse → second pulse ignored; after BURST_DONE, ENABLE_ADC_TEG drops immediately and the state is IDLE with no guard.
- MODE_REQ 01→10→01 within GUARD → guard completes in exactly 4 cycles and ENABLE_DFE returns. BURST_LEN=0 start → no state change.
- RST_N low mid-burst (count=1 of 3) → all outputs 0 asynchronously; no BURST_DONE; after release with MODE_REQ=00, the block stays in IDLE.
- All scenarios: a continuous assertion checks that ENABLE_DFE & ENABLE_ADC_TEG is never 1.
